// File: rtl/dmem_if.sv
// Request/response and SRAM-side signals of the data-memory access unit.
// master = pipeline plus SRAM environment, slave = dmem_access_unit.
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              dmem_sel;
    logic [1:0]        w_sel;
    logic [2:0]        r_sel;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, dmem_sel, w_sel, r_sel, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, dmem_sel, w_sel, r_sel, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store sequencer driving a word-wide synchronous SRAM.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses via resp_err.
module dmem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t            state, next_state;
    logic              accept, is_store, is_load, misalign;
    logic [1:0]        cnt, cnt_d;
    logic [1:0]        off_q;
    logic [2:0]        rsel_q;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [31:0]       load_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign accept = (state == S_IDLE) && bus.req_valid;

    always_comb begin
        is_store = bus.dmem_sel && (bus.w_sel != 2'b11);
        is_load  = !bus.dmem_sel &&
                   (bus.r_sel inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101});
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (is_store)
            misalign = ((bus.w_sel == 2'b01) && bus.req_addr[0]) ||
                       ((bus.w_sel == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        else if (is_load)
            misalign = (((bus.r_sel == 3'b010) || (bus.r_sel == 3'b101)) && bus.req_addr[0]) ||
                       ((bus.r_sel == 3'b011) && (bus.req_addr[1:0] != 2'b00));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (misalign)      next_state = S_RESP;
                    else if (is_store) next_state = S_WRITE;
                    else if (is_load)  next_state = S_READ;
                    else               next_state = S_RESP;
                end
            end
            S_WRITE: next_state = S_RESP;
            S_READ:  next_state = S_WAIT;
            S_WAIT:  if (cnt == 2'd0) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Lane extraction works on the offset and load type latched at acceptance.
    always_comb begin
        lane_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (rsel_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'b0, lane_b};
            3'b010:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'b0, lane_h};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        resp_data_d = resp_data_q;
        cnt_d       = cnt;
        if (accept) begin
            resp_data_d = 32'b0;
            if (next_state == S_WRITE || next_state == S_READ) begin
                mem_en_d   = 1'b1;
                mem_addr_d = bus.req_addr[ADDR_W-1:2];
            end
            if (next_state == S_WRITE) begin
                case (bus.w_sel)
                    2'b00: begin
                        mem_we_d    = 4'b0001 << bus.req_addr[1:0];
                        mem_wdata_d = {4{bus.req_wdata[7:0]}};
                    end
                    2'b01: begin
                        mem_we_d    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata_d = {2{bus.req_wdata[15:0]}};
                    end
                    default: begin
                        mem_we_d    = 4'b1111;
                        mem_wdata_d = bus.req_wdata;
                    end
                endcase
            end
        end
        if (state == S_READ)
            cnt_d = LAT_M1;
        else if (state == S_WAIT && cnt != 2'd0)
            cnt_d = cnt - 2'd1;
        if (state == S_WAIT && cnt == 2'd0)
            resp_data_d = load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 2'd0;
            off_q       <= 2'd0;
            rsel_q      <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            resp_data_q <= 32'b0;
        end else begin
            cnt         <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            resp_data_q <= resp_data_d;
            if (accept) begin
                off_q  <= bus.req_addr[1:0];
                rsel_q <= bus.r_sel;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      resp_err_q <= 1'b0;
        else if (accept) resp_err_q <= misalign;
    end

    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, reset-in-flight sequences and
// random traffic against a byte-array reference; honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_access_unit;
    localparam int LAT = 3;

    typedef struct {
        logic        sel;
        logic [1:0]  ws;
        logic [2:0]  rs;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wdat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          en_cnt;
        logic        en1;
        logic [3:0]  we1;
        logic [29:0] maddr1;
        logic [31:0] wdata1;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0]  ref_mem [0:511];
    logic [31:0] sram    [0:127];
    logic [31:0] rd_pipe [0:LAT-1];
    vec_t        vt[$];

    dmem_if #(.ADDR_W(32)) bus ();

    dmem_access_unit #(.ADDR_W(32), .RD_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM: data for a read issued at edge N is on mem_rdata only between edges N+LAT-1 and N+LAT.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= 32'hBAD0_BAD0;
        if (bus.mem_en) begin
            if (bus.mem_we == 4'b0000) rd_pipe[0] <= sram[bus.mem_addr[6:0]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) sram[bus.mem_addr[6:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] ws, input logic [2:0] rs,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] data, input logic err, input int lat,
                                input logic en, input logic [3:0] we, input logic [31:0] wdat);
        vec_t v;
        v.sel = sel; v.ws = ws; v.rs = rs; v.addr = addr; v.wd = wd;
        v.data = data; v.err = err; v.lat = lat; v.en = en; v.we = we; v.wdat = wdat;
        return v;
    endfunction

    // Reference: bytes of the access are read/written one at a time in a flat byte array.
    task automatic model(inout vec_t v);
        bit          st, ld, sgn, mis;
        int          n, base;
        logic [31:0] val;
        st  = v.sel && (v.ws != 2'b11);
        ld  = !v.sel && (v.rs inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101});
        if (st) n = (v.ws == 2'b00) ? 1 : (v.ws == 2'b01) ? 2 : 4;
        else    n = (v.rs == 3'b000 || v.rs == 3'b100) ? 1 : (v.rs == 3'b011) ? 4 : 2;
        sgn  = (v.rs == 3'b000) || (v.rs == 3'b010);
        mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis  = (st || ld) && (int'(v.addr) % n != 0);
`endif
        base   = int'(v.addr) - int'(v.addr) % n;
        v.data = 32'b0;
        v.err  = mis;
        v.we   = 4'b0000;
        v.wdat = 32'b0;
        v.en   = (st || ld) && !mis;
        if (!v.en) begin
            v.lat = 1;
        end else if (st) begin
            v.lat = 2;
            for (int k = 0; k < n; k++) begin
                ref_mem[base+k]   = v.wd[8*k +: 8];
                v.we[(base+k)%4] = 1'b1;
            end
            for (int i = 0; i < 4; i++) v.wdat[8*i +: 8] = v.wd[8*(i%n) +: 8];
        end else begin
            v.lat = LAT + 2;
            val = 32'b0;
            for (int k = 0; k < n; k++) val[8*k +: 8] = ref_mem[base+k];
            if (sgn && n < 4 && val[8*n-1])
                for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
            v.data = val;
        end
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge after the response.
    task automatic apply(input vec_t v, output obs_t o);
        o.data = 32'b0; o.err = 1'b0; o.lat = 0; o.en_cnt = 0;
        o.en1 = 1'b0; o.we1 = 4'b0; o.maddr1 = 30'b0; o.wdata1 = 32'b0;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.dmem_sel  = v.sel;
        bus.w_sel     = v.ws;
        bus.r_sel     = v.rs;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wd;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 30; k++) begin
            bus.req_valid = 1'($urandom);
            bus.dmem_sel  = 1'($urandom);
            bus.w_sel     = 2'($urandom);
            bus.r_sel     = 3'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            @(negedge clk);
            if (bus.mem_en) o.en_cnt++;
            if (k == 1) begin
                o.en1    = bus.mem_en;
                o.we1    = bus.mem_we;
                o.maddr1 = bus.mem_addr;
                o.wdata1 = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                o.lat  = k;
                o.data = bus.resp_data;
                o.err  = bus.resp_err;
                bus.req_valid = 1'b0;
                @(negedge clk);
                chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
                chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
                return;
            end
            chk("busy_not_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o);
        chk({tag, "_data"}, o.data, v.data);
        chk({tag, "_err"}, 32'(o.err), 32'(v.err));
        chk({tag, "_latency"}, 32'(o.lat), 32'(v.lat));
        chk({tag, "_en_cycles"}, 32'(o.en_cnt), v.en ? 32'd1 : 32'd0);
        if (v.en) begin
            chk({tag, "_en_cycle1"}, 32'(o.en1), 32'd1);
            chk({tag, "_we"}, 32'(o.we1), 32'(v.we));
            chk({tag, "_maddr"}, 32'(o.maddr1), v.addr >> 2);
        end
        if (v.we != 4'b0000) chk({tag, "_wdata"}, o.wdata1, v.wdat);
    endtask

    task automatic reset_in_flight(input string tag, input int cycles_in);
        bit seen;
        bus.req_valid = 1'b1;
        bus.dmem_sel  = 1'b0;
        bus.w_sel     = 2'b11;
        bus.r_sel     = 3'b011;
        bus.req_addr  = 32'h100;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (cycles_in) @(negedge clk);
        chk({tag, "_busy_before"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_en_before"}, 32'(bus.mem_en), (cycles_in == 1) ? 32'd1 : 32'd0);
        rst_n = 1'b0;
        #1;
        chk({tag, "_en_dropped"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "_we_dropped"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_ready_now"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_low"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk({tag, "_no_resp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v, m;
        obs_t        o;
        logic [2:0]  ld_rs [5];
        ld_rs = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.dmem_sel = 1'b0; bus.w_sel = 2'b11;
        bus.r_sel = 3'b111; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 128; w++) begin
            v = mk(1'b1, 2'b10, 3'b111, 32'(w*4), $urandom, 32'h0, 1'b0, 0, 1'b0, 4'h0, 32'h0);
            model(v);
            apply(v, o);
            compare($sformatf("pre%0d", w), v, o);
        end

        vt.push_back(mk(1'b1, 2'b10, 3'b111, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 4'hF, 32'hDEADBEEF));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b00, 3'b111, 32'h103, 32'h000000A5, 32'h0, 1'b0, 2, 1'b1, 4'b1000, 32'hA5A5A5A5));
        vt.push_back(mk(1'b0, 2'b11, 3'b000, 32'h103, 32'h0, 32'hFFFFFFA5, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b100, 32'h103, 32'h0, 32'h000000A5, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b10, 3'b111, 32'h100, 32'h80011234, 32'h0, 1'b0, 2, 1'b1, 4'hF, 32'h80011234));
        vt.push_back(mk(1'b0, 2'b11, 3'b010, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b101, 32'h102, 32'h0, 32'h00008001, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0));
`else
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h102, 32'h0, 32'h80011234, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
`endif
        vt.push_back(mk(1'b0, 2'b11, 3'b111, 32'h100, 32'h0, 32'h0, 1'b0, 1, 1'b0, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b00, 3'b001, 32'h104, 32'h0, 32'h0, 1'b0, 1, 1'b0, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b01, 3'b110, 32'h108, 32'h0, 32'h0, 1'b0, 1, 1'b0, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b11, 3'b000, 32'h100, 32'h12345678, 32'h0, 1'b0, 1, 1'b0, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b01, 3'b111, 32'h102, 32'h0000CAFE, 32'h0, 1'b0, 2, 1'b1, 4'b1100, 32'hCAFECAFE));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hCAFE1234, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b000, 32'h101, 32'h0, 32'h00000012, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b010, 32'h100, 32'h0, 32'h00001234, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b100, 32'h102, 32'h0, 32'h000000FE, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b000, 32'h102, 32'h0, 32'hFFFFFFFE, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vt.push_back(mk(1'b1, 2'b01, 3'b111, 32'h101, 32'h00005678, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hCAFE1234, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b00, 3'b111, 32'h100, 32'h00000080, 32'h0, 1'b0, 2, 1'b1, 4'b0001, 32'h80808080));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hCAFE1280, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
`else
        vt.push_back(mk(1'b1, 2'b01, 3'b111, 32'h101, 32'h00005678, 32'h0, 1'b0, 2, 1'b1, 4'b0011, 32'h56785678));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hCAFE5678, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
        vt.push_back(mk(1'b1, 2'b00, 3'b111, 32'h100, 32'h00000080, 32'h0, 1'b0, 2, 1'b1, 4'b0001, 32'h80808080));
        vt.push_back(mk(1'b0, 2'b11, 3'b011, 32'h100, 32'h0, 32'hCAFE5680, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));
`endif
        vt.push_back(mk(1'b0, 2'b11, 3'b000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0, LAT+2, 1'b1, 4'h0, 32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            m = vt[i];
            model(m);
            apply(vt[i], o);
            compare($sformatf("vec%0d", i), vt[i], o);
        end

        reset_in_flight("rst_in_read", 1);
        reset_in_flight("rst_in_wait", 2);

        for (int i = 0; i < 200; i++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            v = mk(1'($urandom), 2'($urandom), 3'($urandom), 32'($urandom_range(0, 511)), $urandom,
                   32'h0, 1'b0, 0, 1'b0, 4'h0, 32'h0);
            if (pick < 4) begin
                v.sel = 1'b1;
                v.ws  = 2'($urandom_range(0, 2));
            end else if (pick < 9) begin
                v.sel = 1'b0;
                v.rs  = ld_rs[$urandom_range(0, 4)];
            end else if (v.sel) begin
                v.ws  = 2'b11;
            end else begin
                v.rs  = ($urandom_range(0, 2) == 0) ? 3'b001 : ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
            end
            model(v);
            apply(v, o);
            compare($sformatf("rnd%0d", i), v, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
